// File: rtl/ch0re_pkg.sv
// Shared types and constants for the ch0re instruction fetch slice.
// Fetch FSM encoding, the decode-side entry layout, and the fixed nop pattern.
package ch0re_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } ifetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          ILEN_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        misaligned;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] pc_lsbs);
        return pc_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ch0re_fifo_sync.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
// Head entry is presented combinationally so a push becomes visible the next cycle.
module ch0re_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/ch0re_ifetch.sv
// Instruction fetch: credit-limited requests, in-order response matching via a pc
// queue, redirect flush with discard of in-flight responses, misaligned-target halt.
module ch0re_ifetch
    import ch0re_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [63:0] o_pc,
    output logic        o_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_e state_reg;
    logic [63:0]   fetch_pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] discard_reg;
    logic          misalign_pending_reg;
    logic [63:0]   misalign_pc_reg;

    logic          rsp_valid;
    logic          rsp_keep;
    logic          credit;
    logic          fire;

    logic [63:0]   pcq_dout;
    logic          pcq_full;
    logic          pcq_empty;
    logic [CW-1:0] pcq_count;

    fetch_entry_t  buf_din;
    fetch_entry_t  buf_dout;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;

    // A response is only meaningful when something is in flight.
    assign rsp_valid = i_imem_rvalid && (outstanding_reg != '0);
    assign rsp_keep  = rsp_valid && (discard_reg == '0) && !i_redirect && (state_reg == FETCH);

    assign credit      = ({1'b0, outstanding_reg} + {1'b0, buf_count}) < (CW+1)'(FIFO_DEPTH);
    assign o_imem_req  = rst_n && (state_reg == FETCH) && !i_redirect && credit;
    assign o_imem_addr = fetch_pc_reg;
    assign fire        = o_imem_req && i_imem_gnt;

    assign buf_push = misalign_pending_reg || rsp_keep;
    assign buf_din  = misalign_pending_reg ? {NOP_INSTR, misalign_pc_reg, 1'b1}
                                           : {i_imem_rdata, pcq_dout, 1'b0};
    assign buf_pop  = o_valid && i_ready;

    assign o_valid      = rst_n && !buf_empty;
    assign o_instr      = buf_dout.instr;
    assign o_pc         = buf_dout.pc;
    assign o_misaligned = buf_dout.misaligned;

    logic unused_pcq;
    assign unused_pcq = &{1'b0, pcq_full, pcq_empty, pcq_count, buf_full};

    // The pc queue is never flushed: discarded responses still retire their entry.
    ch0re_fifo_sync #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (fire),
        .pop   (rsp_valid),
        .din   (fetch_pc_reg),
        .dout  (pcq_dout),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    ch0re_fifo_sync #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_redirect),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   (buf_din),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg            <= FETCH;
            fetch_pc_reg         <= RESET_PC;
            outstanding_reg      <= '0;
            discard_reg          <= '0;
            misalign_pending_reg <= 1'b0;
            misalign_pc_reg      <= '0;
        end else begin
            outstanding_reg      <= outstanding_reg + CW'(fire) - CW'(rsp_valid);
            misalign_pending_reg <= 1'b0;
            if (i_redirect) begin
                discard_reg <= outstanding_reg - CW'(rsp_valid);
                if (is_misaligned(i_redirect_pc[1:0])) begin
                    state_reg            <= HALT;
                    misalign_pending_reg <= 1'b1;
                    misalign_pc_reg      <= i_redirect_pc;
                end else begin
                    state_reg    <= FETCH;
                    fetch_pc_reg <= i_redirect_pc;
                end
            end else begin
                if (rsp_valid && (discard_reg != '0)) discard_reg <= discard_reg - CW'(1);
                if (fire) fetch_pc_reg <= fetch_pc_reg + 64'(ILEN_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && i_imem_rvalid) begin
            assert (outstanding_reg != '0) else $error("imem response with nothing outstanding");
        end
    end

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Scoreboard bench for ch0re_ifetch: directed windows push expected decode entries,
// a monitor pops and compares on every accepted transfer; memory has a tunable fixed latency.
module tb_ch0re_ifetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [63:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instr;
    logic [63:0] o_pc;
    logic        o_misaligned;

    always #5 clk = ~clk;

    ch0re_ifetch #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_misaligned  (o_misaligned)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];
    int    mem_lat  = 1;
    int    win      = 0;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_xfer   = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push_seq(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{start + 64'(4 * i), mem_word(start + 64'(4 * i)), 1'b0});
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Memory: responds in order exactly mem_lat windows after each grant.
    initial begin
        forever begin
            @(negedge clk);
            win++;
            if (mem_q.size() != 0 && mem_q[0].due <= win) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_word(mem_q[0].addr);
                mem_q.delete(0);
            end else begin
                i_imem_rvalid = 1'b0;
                i_imem_rdata  = 32'hDEAD_BEEF;
            end
            #1;
            if (!rst_n) mem_q.delete();
            else if (o_imem_req && i_imem_gnt) mem_q.push_back('{o_imem_addr, win + mem_lat});
        end
    end

    // Monitor: every accepted transfer must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && o_valid && i_ready && !i_redirect) begin
                n_xfer++;
                $display("xfer pc=%h instr=%h mis=%b", o_pc, o_instr, o_misaligned);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL xfer_unexpected: got pc %0h, required no transfer", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", {o_pc, o_instr, o_misaligned}, {e.pc, e.instr, e.mis});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        i_redirect = 1'b0;
        i_ready    = 1'b1;
        i_imem_gnt = 1'b1;
        mem_lat    = 1;
        exp_q.delete();
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_req", o_imem_req, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        logic halt_bad;

        // Streaming at latency 1: first entry two windows after the first grant, no bubbles.
        do_reset();
        push_seq(64'h0, 12);
        base = n_xfer;
        #1;
        check("first_req", o_imem_req, 1'b1);
        check("first_addr", o_imem_addr, 64'h0);
        for (int w = 1; w <= 11; w++) begin
            @(negedge clk);
            #1;
            if (w >= 2 && w <= 5) begin
                check("stream_valid", o_valid, 1'b1);
                check("stream_pc", o_pc, 64'(4 * (w - 2)));
            end
        end
        @(negedge clk);
        check("stream_count", n_xfer - base, 10);

        // Decode stall: buffer fills to DEPTH, requests stop, resume without loss.
        do_reset();
        i_ready = 1'b0;
        push_seq(64'h0, 16);
        base = n_xfer;
        run(9);
        check("stall_req", o_imem_req, 1'b0);
        check("stall_valid", o_valid, 1'b1);
        check("stall_pc", o_pc, 64'h0);
        check("stall_addr", o_imem_addr, 64'h10);
        @(negedge clk);
        i_ready = 1'b1;
        #1;
        check("resume_req_full", o_imem_req, 1'b0);
        @(negedge clk);
        #1;
        check("resume_req", o_imem_req, 1'b1);
        check("resume_addr", o_imem_addr, 64'h10);
        run(7);
        @(negedge clk);
        check("stall_count", n_xfer - base, 9);

        // Two requests in flight (0x10, 0x14) then redirect to 0x100: both dropped.
        do_reset();
        i_imem_gnt    = 1'b0;
        mem_lat       = 3;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h10;
        #1;
        check("redir_no_req", o_imem_req, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        i_imem_gnt = 1'b1;
        #1;
        check("inflight_req", o_imem_req, 1'b1);
        check("inflight_addr0", o_imem_addr, 64'h10);
        @(negedge clk);
        #1;
        check("inflight_addr1", o_imem_addr, 64'h14);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h100;
        exp_q.delete();
        push_seq(64'h100, 8);
        base = n_xfer;
        #1;
        check("redir2_no_req", o_imem_req, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        check("redir2_addr", o_imem_addr, 64'h100);
        run(10);
        @(negedge clk);
        check("discard_count", (n_xfer - base) >= 4, 1'b1);

        // Misaligned redirect: one marker entry, halt, restart on aligned redirect.
        do_reset();
        push_seq(64'h0, 3);
        base = n_xfer;
        run(4);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h102;
        exp_q.delete();
        exp_q.push_back('{64'h102, 32'h0000_0013, 1'b1});
        #1;
        check("mis_redir_req", o_imem_req, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        check("mis_next_req", o_imem_req, 1'b0);
        halt_bad = 1'b0;
        for (int w = 7; w <= 13; w++) begin
            @(negedge clk);
            #1;
            if (o_imem_req) halt_bad = 1'b1;
            if (w == 7) check("mis_entry", {o_valid, o_misaligned, o_instr}, {1'b1, 1'b1, 32'h0000_0013});
            if (w == 10) check("halt_empty", o_valid, 1'b0);
        end
        check("halt_req", halt_bad, 1'b0);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h200;
        exp_q.delete();
        push_seq(64'h200, 8);
        #1;
        check("halt_exit_req", o_imem_req, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        check("halt_resume_req", o_imem_req, 1'b1);
        check("halt_resume_addr", o_imem_addr, 64'h200);
        run(7);
        @(negedge clk);
        check("mis_count", n_xfer - base, 10);

        // Grant withheld for three windows on address 0x8.
        do_reset();
        push_seq(64'h0, 10);
        base = n_xfer;
        run(1);
        for (int w = 2; w <= 4; w++) begin
            @(negedge clk);
            i_imem_gnt = 1'b0;
            #1;
            check("nognt_req", o_imem_req, 1'b1);
            check("nognt_addr", o_imem_addr, 64'h8);
        end
        @(negedge clk);
        i_imem_gnt = 1'b1;
        #1;
        check("gnt_addr", o_imem_addr, 64'h8);
        @(negedge clk);
        #1;
        check("gnt_advance", o_imem_addr, 64'hC);
        run(6);
        @(negedge clk);
        check("gnt_count", n_xfer - base, 8);

        // Redirect with pop on a full buffer, then redirect coincident with rvalid and pop.
        do_reset();
        i_ready = 1'b0;
        base = n_xfer;
        run(9);
        check("full_valid", o_valid, 1'b1);
        @(negedge clk);
        i_ready       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h300;
        exp_q.delete();
        push_seq(64'h300, 16);
        #1;
        check("full_redir_req", o_imem_req, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        check("full_flush", o_valid, 1'b0);
        check("full_restart_addr", o_imem_addr, 64'h300);
        run(7);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h400;
        exp_q.delete();
        push_seq(64'h400, 10);
        #1;
        check("coinc_valid", {o_valid, i_imem_rvalid}, 2'b11);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        check("coinc_flush", o_valid, 1'b0);
        run(8);
        @(negedge clk);
        check("coinc_count", n_xfer - base, 13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
